// File: rtl/race_pkg.sv
// Shared definitions for the RACE input scheduler: FSM encoding, default
// parameter values and counter-width helpers.
package race_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RESYNC = 2'd1;
  localparam logic [1:0] ST_FEED   = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  localparam int L_DEF          = 7;
  localparam int IN_SIZE_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF    = 2*L_DEF + 8;

  // Width of the WAIT cycle counter for a given timeout.
  function automatic int wait_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Width of a FIFO occupancy count, 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int WAIT_CNT_W = wait_cnt_w(TIMEOUT_DEF);
  localparam int LEVEL_W    = level_w(FIFO_DEPTH_DEF);

endpackage

// File: rtl/race_sample_fifo.sv
// Small synchronous sample FIFO. Full/empty are registered; read data is
// registered on pop so the consumer sees a stable word until the next pop.
module race_sample_fifo
  import race_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int LW    = level_w(DEPTH)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          r_full, r_empty;
  logic [W-1:0]  r_rdata;

  logic          w_push, w_pop;
  logic [LW-1:0] w_level_nxt;

  // A push into a full FIFO is refused even when a pop happens in the same cycle.
  assign w_push      = i_push && !r_full;
  assign w_pop       = i_pop && !r_empty;
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers (wrap naturally, depth is a power of two), level and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_rdata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_rdata <= r_mem[r_rptr];
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/race_in_sched.sv
// Input scheduler feeding the RACE adaptive filter: buffers complex samples,
// issues a strobe_resync / valid_in pair per sample, holds the sample for the
// tap window and waits for data_ready, flagging a sticky timeout if it never
// comes. Optional statistics counters are built when RACE_SCHED_STATS_EN is
// defined.
module race_in_sched
  import race_pkg::*;
#(
  parameter int L          = L_DEF,
  parameter int IN_SIZE    = IN_SIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TIMEOUT    = 2*L + 8
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [IN_SIZE-1:0]            s_real,
  input  logic [IN_SIZE-1:0]            s_imag,
  output logic                          race_strobe_resync,
  output logic                          race_valid_in,
  output logic [IN_SIZE-1:0]            race_real,
  output logic [IN_SIZE-1:0]            race_imag,
  input  logic                          race_data_ready,
  output logic                          busy,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic                          err_timeout
`ifdef RACE_SCHED_STATS_EN
  ,
  output logic [31:0]                   sample_cnt,
  output logic [15:0]                   timeout_cnt
`endif
);

  localparam int CW = wait_cnt_w(TIMEOUT);
  localparam int LW = level_w(FIFO_DEPTH);

  logic [1:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_err;

  logic [1:0]           w_state_nxt;
  logic                 w_pop;
  logic                 w_timeout;
  logic                 w_full, w_empty;
  logic [LW-1:0]        w_level;
  logic [2*IN_SIZE-1:0] w_rdata;

  race_sample_fifo #(
    .W     (2*IN_SIZE),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_valid),
    .i_wdata ({s_real, s_imag}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Next-state and pop decision; data_ready outside WAIT is a stale pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_RESYNC;
        end
      end
      ST_RESYNC: w_state_nxt = ST_FEED;
      ST_FEED:   w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // data_ready takes priority over a timeout landing in the same cycle.
        if (race_data_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_RESYNC;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (r_cnt == CW'(TIMEOUT-1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // WAIT cycle counter: cleared in FEED, counts every WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_cnt <= '0;
    else if (r_state == ST_FEED) r_cnt <= '0;
    else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
  end

  // Sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

`ifdef RACE_SCHED_STATS_EN
  logic [31:0] r_sample_cnt;
  logic [15:0] r_timeout_cnt;

  // Saturating counts of issued samples (RESYNC entries) and timeouts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_cnt  <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (w_pop && (r_sample_cnt != '1))      r_sample_cnt  <= r_sample_cnt + 1'b1;
      if (w_timeout && (r_timeout_cnt != '1)) r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end

  assign sample_cnt  = r_sample_cnt;
  assign timeout_cnt = r_timeout_cnt;
`endif

  assign s_ready            = !w_full;
  assign race_strobe_resync = (r_state == ST_RESYNC);
  assign race_valid_in      = (r_state == ST_FEED);
  assign race_real          = w_rdata[2*IN_SIZE-1:IN_SIZE];
  assign race_imag          = w_rdata[IN_SIZE-1:0];
  assign busy               = (r_state != ST_IDLE);
  assign fifo_level         = w_level;
  assign err_timeout        = r_err;

endmodule

// File: tb/tb_race_in_sched.sv
// Bench for race_in_sched: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a queue-based model.
module tb_race_in_sched;
  import race_pkg::*;

  localparam int L       = 7;
  localparam int IN_SIZE = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 2*L + 8;
  localparam int LW      = LEVEL_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               s_valid = 1'b0;
  logic [IN_SIZE-1:0] s_real = '0, s_imag = '0;
  logic               race_data_ready = 1'b0;
  logic               s_ready, race_strobe_resync, race_valid_in, busy, err_timeout;
  logic [IN_SIZE-1:0] race_real, race_imag;
  logic [LW-1:0]      fifo_level;
`ifdef RACE_SCHED_STATS_EN
  logic [31:0]        sample_cnt;
  logic [15:0]        timeout_cnt;
`endif

  race_in_sched #(.L(L), .IN_SIZE(IN_SIZE), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_real(s_real), .s_imag(s_imag),
    .race_strobe_resync(race_strobe_resync), .race_valid_in(race_valid_in),
    .race_real(race_real), .race_imag(race_imag),
    .race_data_ready(race_data_ready), .busy(busy),
    .fifo_level(fifo_level), .err_timeout(err_timeout)
`ifdef RACE_SCHED_STATS_EN
    , .sample_cnt(sample_cnt), .timeout_cnt(timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sample queue and a phase number
  // (-1 idle, 0 strobe cycle, 1 valid cycle, 2+k the k-th wait cycle).
  logic [2*IN_SIZE-1:0] mq[$];
  int                   m_phase = -1;
  logic [IN_SIZE-1:0]   m_real = '0, m_imag = '0;
  bit                   m_err = 0;
  int                   m_scnt = 0, m_tcnt = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [2*IN_SIZE-1:0] w;
    bit rdy;
    if (rst) begin
      mq.delete(); m_phase = -1; m_real = '0; m_imag = '0;
      m_err = 0; m_scnt = 0; m_tcnt = 0;
    end else begin
      rdy = (mq.size() < DEPTH);
      if (m_phase == -1) begin
        if (mq.size() > 0) begin
          w = mq.pop_front(); {m_real, m_imag} = w; m_phase = 0; m_scnt++;
        end
      end else if (m_phase < 2) begin
        m_phase++;
      end else if (race_data_ready) begin
        if (mq.size() > 0) begin
          w = mq.pop_front(); {m_real, m_imag} = w; m_phase = 0; m_scnt++;
        end else m_phase = -1;
      end else if (m_phase - 2 == TIMEOUT - 1) begin
        m_err = 1; m_tcnt++; m_phase = -1;
      end else m_phase++;
      if (s_valid && rdy) mq.push_back({s_real, s_imag});
    end
  end

  // Strobe log for ordering/spacing checks, and a flag for back-pressure seen.
  int                   st_cyc[$];
  logic [2*IN_SIZE-1:0] st_val[$];
  bit                   saw_full = 0;

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("s_ready",     32'(s_ready),            32'(mq.size() < DEPTH));
    chk("fifo_level",  32'(fifo_level),         32'(mq.size()));
    chk("strobe",      32'(race_strobe_resync), 32'(m_phase == 0));
    chk("valid_in",    32'(race_valid_in),      32'(m_phase == 1));
    chk("busy",        32'(busy),               32'(m_phase != -1));
    chk("race_real",   32'(race_real),          32'(m_real));
    chk("race_imag",   32'(race_imag),          32'(m_imag));
    chk("err_timeout", 32'(err_timeout),        32'(m_err));
`ifdef RACE_SCHED_STATS_EN
    chk("sample_cnt",  sample_cnt,              32'(m_scnt));
    chk("timeout_cnt", 32'(timeout_cnt),        32'(m_tcnt));
`endif
    if (race_strobe_resync) begin
      st_cyc.push_back(cyc);
      st_val.push_back({race_real, race_imag});
    end
    if (fifo_level == LW'(DEPTH) && !s_ready) saw_full = 1;
  end

  // RACE responder: data_ready dr_delay cycles after valid_in, unless 'never'.
  int cd = -1, dr_delay = 17;
  bit never = 0, noise = 0, last_acc = 0;

  task automatic step();
    bit pre = s_valid && s_ready;
    @(posedge clk); #1;
    last_acc = pre;
    if (race_valid_in && !never) cd = dr_delay;
    else if (cd >= 0) cd--;
    race_data_ready = (cd == 0) || (noise && ($urandom_range(0, 7) == 0));
  endtask

  task automatic push(input logic [IN_SIZE-1:0] re, input logic [IN_SIZE-1:0] im, input int budget);
    s_valid = 1'b1; s_real = re; s_imag = im;
    for (int i = 0; i < budget; i++) begin
      step();
      if (last_acc) break;
    end
    chk("push_accept", 32'(last_acc), 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (!busy && fifo_level == '0) break;
    end
    chk("idle_reached", 32'(!busy && fifo_level == '0), 32'd1);
  endtask

  task automatic wait_valid(input int budget, output int vc);
    vc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (race_valid_in) begin vc = cyc; break; end
    end
    chk("valid_seen", 32'(vc >= 0), 32'd1);
  endtask

  task automatic do_reset();
    noise = 0; never = 0; cd = -1; s_valid = 1'b0; race_data_ready = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, n0, got;
    logic [IN_SIZE-1:0] br [6];
    logic [IN_SIZE-1:0] bi [6];

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_s_ready", 32'(s_ready),     32'd1);
    chk("rst_level",   32'(fifo_level),  32'd0);
    chk("rst_err",     32'(err_timeout), 32'd0);
    chk("rst_real",    32'(race_real),   32'd0);
    step(); rst = 1'b0; step();

    // Single sample into an idle block
    push(16'h1234, 16'hFEDC, 5);
    @(negedge clk);
    chk("t1_no_strobe_yet", 32'(race_strobe_resync), 32'd0);
    chk("t1_level1",        32'(fifo_level),         32'd1);
    step(); @(negedge clk);
    chk("t1_strobe", 32'(race_strobe_resync), 32'd1);
    chk("t1_real",   32'(race_real),          32'h1234);
    chk("t1_imag",   32'(race_imag),          32'hFEDC);
    chk("t1_model_real", 32'(m_real),         32'h1234);
    step(); @(negedge clk);
    chk("t1_valid", 32'(race_valid_in), 32'd1);
    repeat (17) step();
    @(negedge clk);
    chk("t1_busy_at_dr", 32'(busy), 32'd1);
    step(); @(negedge clk);
    chk("t1_busy_drop", 32'(busy), 32'd0);
    chk("t1_model_idle", 32'(m_phase), 32'hFFFF_FFFF);

    // Burst of 6 with depth 4
    st_cyc.delete(); st_val.delete(); saw_full = 0;
    for (int k = 0; k < 6; k++) begin
      br[k] = 16'h1000 + 16'(k * 17);
      bi[k] = 16'hA000 - 16'(k * 3);
      push(br[k], bi[k], 200);
    end
    wait_idle(200);
    chk("t2_saw_full", 32'(saw_full),      32'd1);
    chk("t2_count",    32'(st_cyc.size()), 32'd6);
    if (st_cyc.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("t2_order", st_val[k], {br[k], bi[k]});
        if (k > 0) chk("t2_spacing", 32'(st_cyc[k] - st_cyc[k-1]), 32'd19);
      end
    end

    // Timeout with a second sample queued
    never = 1;
    push(16'h0AAA, 16'h0555, 5);
    push(16'h0BBB, 16'h0666, 5);
    wait_valid(10, v);
    while (cyc < v + TIMEOUT) step();
    @(negedge clk);
    chk("t3_err_before", 32'(err_timeout), 32'd0);
    chk("t3_busy_before", 32'(busy), 32'd1);
    step(); @(negedge clk);
    chk("t3_err_rise", 32'(err_timeout), 32'd1);
    chk("t3_idle",     32'(busy),        32'd0);
    never = 0; dr_delay = 17;
    step(); @(negedge clk);
    chk("t3_next_strobe", 32'(race_strobe_resync), 32'd1);
    chk("t3_next_real",   32'(race_real),          32'h0BBB);
    wait_idle(100);
    chk("t3_err_sticky", 32'(err_timeout), 32'd1);

    // data_ready on the final timeout cycle wins
    do_reset();
    @(negedge clk);
    chk("t4_err_cleared", 32'(err_timeout), 32'd0);
    dr_delay = TIMEOUT;
    push(16'h0C0C, 16'h0D0D, 5);
    push(16'h0E0E, 16'h0F0F, 5);
    wait_valid(10, v);
    while (cyc < v + TIMEOUT + 1) step();
    @(negedge clk);
    chk("t4_no_err",   32'(err_timeout),        32'd0);
    chk("t4_strobe",   32'(race_strobe_resync), 32'd1);
    chk("t4_real",     32'(race_real),          32'h0E0E);
    dr_delay = 17;
    wait_idle(100);
    chk("t4_no_err_end", 32'(err_timeout), 32'd0);

    // Asynchronous reset in WAIT with 3 queued
    do_reset();
    never = 1;
    for (int k = 0; k < 4; k++) push(16'h2000 + 16'(k), 16'h3000 + 16'(k), 5);
    step(); @(negedge clk);
    chk("t5_level3", 32'(fifo_level), 32'd3);
    chk("t5_in_wait", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_level0",   32'(fifo_level),         32'd0);
    chk("t5_busy0",    32'(busy),               32'd0);
    chk("t5_strobe0",  32'(race_strobe_resync), 32'd0);
    chk("t5_valid0",   32'(race_valid_in),      32'd0);
    chk("t5_real0",    32'(race_real),          32'd0);
    chk("t5_imag0",    32'(race_imag),          32'd0);
    chk("t5_s_ready1", 32'(s_ready),            32'd1);
    step(); step(); rst = 1'b0; never = 0; cd = -1;
    n0 = st_cyc.size();
    repeat (30) step();
    chk("t5_no_strobe", 32'(st_cyc.size()), 32'(n0));
    push(16'h4444, 16'h5555, 5);
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      if (race_strobe_resync) got = 1;
    end
    chk("t5_strobe_after_push", 32'(got), 32'd1);
    wait_idle(100);

    // Randomized traffic, stale pulses, variable RACE latency, rare resets
    noise = 1;
    for (int it = 0; it < 3000; it++) begin
      s_valid = ($urandom_range(0, 2) != 0);
      s_real  = 16'($urandom);
      s_imag  = 16'($urandom);
      if ($urandom_range(0, 31) == 0) begin
        dr_delay = $urandom_range(8, TIMEOUT + 4);
        never    = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1; step(); rst = 1'b0;
      end else step();
    end
    s_valid = 1'b0; noise = 0; never = 0; dr_delay = 17;
    wait_idle(300);

`ifdef RACE_SCHED_STATS_EN
    // Statistics: 5 samples, one of them timing out
    do_reset();
    never = 1;
    push(16'h0001, 16'h0001, 5);
    for (int i = 0; i < 40 && !err_timeout; i++) step();
    never = 0;
    for (int k = 0; k < 4; k++) push(16'h0010 + 16'(k), 16'h0020, 60);
    wait_idle(300);
    @(negedge clk);
    chk("st_sample_cnt",  sample_cnt,         32'd5);
    chk("st_timeout_cnt", 32'(timeout_cnt),   32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
